// File: rtl/pixel_arb_pkg.sv
// Shared widths, grant-state encoding and index-width helper for pixel_write_arbiter.
package pixel_arb_pkg;

  localparam int unsigned DEF_XW = 8;
  localparam int unsigned DEF_YW = 8;
  localparam int unsigned DEF_CW = 3;
  localparam int unsigned DROP_W = 16;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;

  // Width of a source index; never below 1 so a 2-source build still has a bit.
  function automatic int unsigned src_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant starting at ptr; a held lock restricts the grant to lock_src.
module rr_arbiter import pixel_arb_pkg::*; #(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned SW    = src_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SW-1:0]    ptr,
  input  logic             lock,
  input  logic [SW-1:0]    lock_src,
  output logic [N_SRC-1:0] grant
);

  logic          found;
  logic [SW-1:0] idx;
  int unsigned   pos;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    if (lock) begin
      grant[lock_src] = req[lock_src];
    end else begin
      for (int unsigned k = 0; k < N_SRC; k++) begin
        pos = 32'(ptr) + k;
        if (pos >= N_SRC) pos = pos - N_SRC;
        idx = SW'(pos);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Merges N_SRC pixel streams into one registered write port with round-robin or frame-lock
// arbitration. Optional coordinate clipping and drop counter: define PIXEL_ARB_CLIP_EN.
module pixel_write_arbiter import pixel_arb_pkg::*; #(
  parameter int unsigned N_SRC      = 2,
  parameter int unsigned XW         = DEF_XW,
  parameter int unsigned YW         = DEF_YW,
  parameter int unsigned CW         = DEF_CW,
  parameter int unsigned LOCK_FRAME = 0,
  parameter int unsigned H_ACTIVE   = 256,
  parameter int unsigned V_ACTIVE   = 256
) (
  input  logic                      clock,
  input  logic                      not_reset,
  input  logic [N_SRC-1:0]          in_valid,
  output logic [N_SRC-1:0]          in_ready,
  input  logic [N_SRC-1:0]          in_last,
  input  logic [N_SRC*XW-1:0]       in_x,
  input  logic [N_SRC*YW-1:0]       in_y,
  input  logic [N_SRC*CW-1:0]       in_r,
  input  logic [N_SRC*CW-1:0]       in_g,
  input  logic [N_SRC*CW-1:0]       in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XW-1:0]             oX,
  output logic [YW-1:0]             oY,
  output logic [CW-1:0]             oR,
  output logic [CW-1:0]             oG,
  output logic [CW-1:0]             oB,
  output logic [src_w(N_SRC)-1:0]   oSrc,
  output logic                      oLast,
  output logic                      frame_done
`ifdef PIXEL_ARB_CLIP_EN
  ,
  output logic [DROP_W-1:0]         drop_count
`endif
);

  localparam int unsigned SW = src_w(N_SRC);

  arb_state_e      state_q;
  logic [SW-1:0]   ptr_q, lock_src_q, ptr_d;
  logic            out_valid_q, last_q, frame_done_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [CW-1:0]   r_q, g_q, b_q;
  logic [SW-1:0]   src_q;

  logic [N_SRC-1:0] grant;
  logic             load, xfer, clip, fwd, sel_last;
  logic [SW-1:0]    sel_idx;
  logic [XW-1:0]    sel_x;
  logic [YW-1:0]    sel_y;
  logic [CW-1:0]    sel_r, sel_g, sel_b;

  rr_arbiter #(
    .N_SRC (N_SRC),
    .SW    (SW)
  ) u_rr_arbiter (
    .req      (in_valid),
    .ptr      (ptr_q),
    .lock     (state_q == ARB_LOCKED),
    .lock_src (lock_src_q),
    .grant    (grant)
  );

  assign load     = ~out_valid_q | out_ready;
  assign in_ready = grant & {N_SRC{load & not_reset}};
  assign xfer     = |in_ready;

  always_comb begin
    sel_idx  = '0;
    sel_x    = '0;
    sel_y    = '0;
    sel_r    = '0;
    sel_g    = '0;
    sel_b    = '0;
    sel_last = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (grant[k]) begin
        sel_idx  = SW'(k);
        sel_x    = in_x[k*XW +: XW];
        sel_y    = in_y[k*YW +: YW];
        sel_r    = in_r[k*CW +: CW];
        sel_g    = in_g[k*CW +: CW];
        sel_b    = in_b[k*CW +: CW];
        sel_last = in_last[k];
      end
    end
  end

`ifdef PIXEL_ARB_CLIP_EN
  logic [DROP_W-1:0] drop_q;
  assign clip       = (32'(sel_x) >= H_ACTIVE) || (32'(sel_y) >= V_ACTIVE);
  assign drop_count = drop_q;
`else
  assign clip = 1'b0;
`endif

  assign fwd   = xfer & ~clip;
  assign ptr_d = (sel_idx == SW'(N_SRC - 1)) ? '0 : sel_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (!not_reset) begin
      state_q      <= ARB_OPEN;
      ptr_q        <= '0;
      lock_src_q   <= '0;
      out_valid_q  <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      src_q        <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PIXEL_ARB_CLIP_EN
      drop_q       <= '0;
`endif
    end else begin
      frame_done_q <= out_valid_q & out_ready & last_q;
      if (fwd) begin
        out_valid_q <= 1'b1;
        x_q         <= sel_x;
        y_q         <= sel_y;
        r_q         <= sel_r;
        g_q         <= sel_g;
        b_q         <= sel_b;
        src_q       <= sel_idx;
        last_q      <= sel_last;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      // While locked the granted source is lock_src, so sel_idx+1 equals lock_src+1 on release.
      if (xfer) begin
        if (LOCK_FRAME != 0) begin
          if (sel_last) begin
            state_q <= ARB_OPEN;
            ptr_q   <= ptr_d;
          end else begin
            state_q    <= ARB_LOCKED;
            lock_src_q <= sel_idx;
          end
        end else begin
          ptr_q <= ptr_d;
        end
      end
`ifdef PIXEL_ARB_CLIP_EN
      if (xfer && clip && (drop_q != '1)) drop_q <= drop_q + 1'b1;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign oX         = x_q;
  assign oY         = y_q;
  assign oR         = r_q;
  assign oG         = g_q;
  assign oB         = b_q;
  assign oSrc       = src_q;
  assign oLast      = last_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Merges pixel writes from `N_SRC` independent pixel producers into the single write port of the frame-buffer/VGA controller. It generalises the current point-to-point link, in which one processing unit drives one x/y/r/g/b write port. Coordinate and colour widths are parametrised, and per-source valid/ready handshakes with round-robin arbitration are added. An optional frame-lock mode keeps one source granted until it completes a frame. The block sits between the pixel processing units (e.g. the adaptive-threshold unit and future filters) and the display controller's write inputs.

## Interface
- `N_SRC`, 2, number of pixel sources (2..8)
- `XW`, 8, x coordinate width
- `YW`, 8, y coordinate width
- `CW`, 3, bits per colour channel
- `LOCK_FRAME`, 0, 1 = a granted source keeps the grant until it transfers a pixel with `in_last`
- `H_ACTIVE`, 256, x clip bound (used only with the clip feature)
- `V_ACTIVE`, 256, y clip bound (used only with the clip feature)
- `clock`  in  1  single clock for all logic
- `not_reset`  in  1  reset, synchronous and active-low
- `in_valid`  in  N_SRC  per-source pixel valid
- `in_ready`  out  N_SRC  per-source accept
- `in_last`  in  N_SRC  pixel is the last of a frame
- `in_x`  in  N_SRC*XW  packed x; source i occupies `[i*XW +: XW]`
- `in_y`  in  N_SRC*YW  packed y
- `in_r`, `in_g`, `in_b`  in  N_SRC*CW each  packed colour
- `out_valid`  out  1  output pixel valid
- `out_ready`  in  1  controller accepts the output pixel
- `oX`, `oY`  out  XW / YW  output coordinates
- `oR`, `oG`, `oB`  out  CW each  output colour
- `oSrc`  out  clog2(N_SRC)  index of the source that produced the output pixel
- `oLast`  out  1  forwarded `in_last`
- `frame_done`  out  1  one-cycle pulse on an output transfer with `oLast=1`
- `drop_count`  out  16  clipped-pixel counter (present only with `PIXEL_ARB_CLIP_EN`)

## Operation
- Single output register stage. `load = ~out_valid | out_ready`.
- Arbitration is round-robin. The search starts at `ptr`. The grant goes to the first index at or after `ptr`, wrapping, with `in_valid=1`.
- `in_ready[i] = grant[i] & load`. At most one `in_ready` is high in any cycle.
- Input transfer on source i means `in_valid[i] & in_ready[i]`. On that transfer the output register loads the source's fields, sets `oSrc=i`, and sets `out_valid=1`.
- After a transfer from source i with `LOCK_FRAME=0`, `ptr <= i+1` (mod `N_SRC`).
- With `LOCK_FRAME=1`:
  - The first transfer from source i sets `lock=1` and `lock_src=i`.
  - While `lock=1`, only `lock_src` may be granted, even if it is idle.
  - A transfer with `in_last=1` clears `lock` and sets `ptr <= lock_src+1`.
- Output transfer means `out_valid & out_ready`. If no input transfer happens in the same cycle, `out_valid <= 0`. A simultaneous output and input transfer gives back-to-back throughput of one pixel per cycle.
- When `out_valid=1` and `out_ready=0`, all outputs hold stable and all `in_ready` are 0.
- Reset values (synchronous, `not_reset=0` at a clock edge):
  - outputs: `out_valid=0`, `oX`/`oY`/`oR`/`oG`/`oB`/`oSrc`/`oLast`=0, `frame_done=0`, `drop_count=0`
  - internal state: `ptr=0`, `lock=0`
  - A pixel in flight in the output register is discarded.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`.
- `frame_done` is registered. It is high in the cycle after the output transfer of the `oLast` pixel.
- `in_ready` is combinational from `in_valid`, `out_ready` and state. There is no combinational path from `in_*` data to outputs.
- Sustained throughput is 1 pixel/cycle when `out_ready` is held high.

## Configuration
- With `PIXEL_ARB_CLIP_EN` defined:
  - A granted pixel with `x >= H_ACTIVE` or `y >= V_ACTIVE` is still accepted (`in_ready` high) but is not loaded.
  - `out_valid` follows the no-input-transfer rule for that cycle.
  - `drop_count` increments and saturates at `16'hFFFF`.
  - A clipped pixel with `in_last=1` still releases the lock, but it produces no `frame_done`.
- Without the macro, every accepted pixel is forwarded and the `drop_count` port does not exist.

## Structure
- Package `pixel_arb_pkg`: default widths (`XW`/`YW`/`CW`), a source-index width function (clog2), and the `drop_count` width constant of 16.
- Sub-module `rr_arbiter`: takes `N_SRC`, `req`, `ptr`, `lock`, `lock_src` and returns a one-hot `grant`. The datapath and pointer/lock registers stay in `pixel_write_arbiter`.

## Test plan
- Reset: drive `not_reset=0` for 2 cycles with all `in_valid=1` -> `out_valid=0`, `in_ready=0`, `ptr=0`. The first transfer after release comes from source 0.
- Fairness: `N_SRC=4`, all valid continuously, `out_ready=1` -> `oSrc` sequence 0,1,2,3,0,…; one pixel per cycle with no gaps.
- Backpressure: hold `out_ready=0` for 5 cycles with the output full -> `oX`/`oY`/colour stable and all `in_ready=0`. Release -> next pixel appears the following cycle.
- Frame lock: `LOCK_FRAME=1`, sources 0 and 1 valid, source 0 sends 4 pixels with the 4th having `in_last=1` -> output is 4 pixels from source 0, `frame_done` pulses once, next grant goes to source 1.
- Clip (macro on, `H_ACTIVE=160`): source sends x=159 then x=160 -> only x=159 is output and `drop_count=1`.
- Mid-frame reset: assert reset with the lock held and `out_valid=1` -> next cycle `out_valid=0`, `lock=0`, arbitration restarts at source 0.
